// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate data cache: 8 lines x 4 bytes, byte-wide CPU port, 32-bit block port to memory.
// Latency: hits complete in the request cycle; a miss adds writeback (dirty only) + fetch + one FILL cycle, then retries as a hit.
// Backpressure: busywait stalls the CPU on a miss; mem_busywait holds WRITEBACK/FETCH until it reads 0 on a rising edge.
//
// Ports:
//   CLK, RESET (sync, active-low)
//   CPU side:    read, write, address[7:0], writedata[7:0] -> readdata[7:0], busywait
//   Memory side: mem_read, mem_write, mem_address[5:0], mem_writedata[31:0] <- mem_readdata[31:0], mem_busywait
module dcache (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    output logic        busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        FILL      = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // Line storage. Data and tags are not reset: valid gates every use of them.
    logic [31:0] data_arr [8];
    logic [2:0]  tag_arr  [8];
    logic [7:0]  valid;
    logic [7:0]  dirty;

    logic [2:0]  addr_tag;
    logic [2:0]  idx;
    logic [1:0]  off;
    logic [31:0] line;
    logic [7:0]  sel_byte;
    logic        hit;
    logic        req;

    assign addr_tag = address[7:5];
    assign idx      = address[4:2];
    assign off      = address[1:0];
    assign line     = data_arr[idx];
    assign sel_byte = line[{off, 3'b000} +: 8];
    assign hit      = valid[idx] && (tag_arr[idx] == addr_tag);
    assign req      = read || write;

    always_comb begin
        next_state    = state;
        busywait      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = {addr_tag, idx};
        mem_writedata = line;
        readdata      = 8'h00;

        case (state)
            IDLE: begin
                if (req) begin
                    busywait = !hit;
                    if (!hit) begin
                        next_state = (valid[idx] && dirty[idx]) ? WRITEBACK : FETCH;
                    end
                    // read+write together is a store, so no load data is returned
                    if (read && !write && hit) begin
                        readdata = sel_byte;
                    end
                end
            end
            WRITEBACK: begin
                busywait    = 1'b1;
                mem_write   = 1'b1;
                // victim block address comes from the stored tag, not the request
                mem_address = {tag_arr[idx], idx};
                if (!mem_busywait) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                busywait = 1'b1;
                mem_read = 1'b1;
                if (!mem_busywait) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                busywait   = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && write && hit) begin
                data_arr[idx][{off, 3'b000} +: 8] <= writedata;
                dirty[idx]                        <= 1'b1;
            end
            if (state == FILL) begin
                data_arr[idx] <= mem_readdata;
                tag_arr[idx]  <= addr_tag;
                valid[idx]    <= 1'b1;
                dirty[idx]    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: table-driven hit vectors plus hand-written miss, writeback and reset-abort sequences.
// Memory model answers with LAT busy cycles per transfer and latches fetched data for the FILL cycle.
// Counts comparisons and mismatches and prints one summary line.
module tb_dcache;

    localparam int LAT = 3;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    always #5 CLK = ~CLK;

    dcache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .read         (read),
        .write        (write),
        .address      (address),
        .writedata    (writedata),
        .readdata     (readdata),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_writedata(mem_writedata),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem [0:63];
    logic        mem_loaded = 1'b0;
    logic [31:0] rdata_q = 32'h0;
    int          busy_cnt = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [5:0]  last_rd_addr = '0;
    logic [5:0]  last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    int          overlap = 0;

    assign mem_busywait = (mem_read || mem_write) && (busy_cnt < LAT);
    assign mem_readdata = rdata_q;

    always @(posedge CLK) begin
        if (!RESET && !mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0]     <= 32'h44332211;
            mem[1]     <= 32'hDDCCBBAA;
            mem[8]     <= 32'h88776655;
            mem[9]     <= 32'h12345678;
            mem_loaded <= 1'b1;
        end
        if (mem_read || mem_write) begin
            if (mem_busywait) begin
                busy_cnt <= busy_cnt + 1;
            end else begin
                busy_cnt <= 0;
                if (mem_write) begin
                    mem[mem_address] <= mem_writedata;
                    wr_cnt           <= wr_cnt + 1;
                    last_wr_addr     <= mem_address;
                    last_wr_data     <= mem_writedata;
                end
                if (mem_read) begin
                    rdata_q      <= mem[mem_address];
                    rd_cnt       <= rd_cnt + 1;
                    last_rd_addr <= mem_address;
                end
            end
        end else begin
            busy_cnt <= 0;
        end
    end

    always @(negedge CLK) begin
        if (mem_read && mem_write) overlap <= overlap + 1;
    end

    // ---------------- checking ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request starting just after a rising edge; hold it until busywait is
    // seen low at a falling edge, then drop it after the following rising edge.
    task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                          input logic [7:0] wd, output int stalls,
                          output logic [7:0] rv, output logic first_busy);
        logic done;
        read      = rd;
        write     = wr;
        address   = a;
        writedata = wd;
        stalls     = 0;
        rv         = 8'h00;
        first_busy = 1'b0;
        done       = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (i == 0) first_busy = busywait;
            if (!busywait) begin
                rv   = readdata;
                done = 1'b1;
                break;
            end
            stalls++;
            @(posedge CLK);
            #1;
        end
        chk("access_completes", {31'b0, done}, 32'd1);
        @(posedge CLK);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    typedef struct {
        string      name;
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wd;
        logic       exp_busy;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [7];

    int         stalls;
    logic [7:0] rv;
    logic       fb;
    int         rd_before;
    int         wr_before;

    initial begin
        // Hit vectors, valid once line 0 holds block 0 (0x44332211).
        vecs[0] = '{"hit_rd_03",  1'b1, 1'b0, 8'h03, 8'h00, 1'b0, 8'h44};
        vecs[1] = '{"hit_rd_02",  1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 8'h33};
        vecs[2] = '{"hit_wr_01",  1'b0, 1'b1, 8'h01, 8'hAB, 1'b0, 8'h00};
        vecs[3] = '{"hit_rd_01",  1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 8'hAB};
        vecs[4] = '{"hit_rd_00",  1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h11};
        vecs[5] = '{"no_request", 1'b0, 1'b0, 8'h07, 8'h00, 1'b0, 8'h00};
        vecs[6] = '{"hit_rd_03b", 1'b1, 1'b0, 8'h03, 8'h00, 1'b0, 8'h44};

        RESET = 1'b0; read = 1'b0; write = 1'b0; address = 8'h00; writedata = 8'h00;

        // Reset state, observed while RESET is held low.
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_busywait",  {31'b0, busywait},  32'd0);
        chk("rst_mem_read",  {31'b0, mem_read},  32'd0);
        chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
        chk("rst_readdata",  {24'b0, readdata},  32'd0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;

        // Cold read miss on 0x00: IDLE(1) + FETCH(LAT+1) + FILL(1) stall cycles.
        access(1'b1, 1'b0, 8'h00, 8'h00, stalls, rv, fb);
        chk("miss00_first_busy", {31'b0, fb}, 32'd1);
        chk("miss00_stalls", stalls, 32'd6);
        chk("miss00_readdata", {24'b0, rv}, 32'h11);
        chk("miss00_rd_cnt", rd_cnt, 32'd1);
        chk("miss00_rd_addr", {26'b0, last_rd_addr}, 32'h00);
        chk("miss00_wr_cnt", wr_cnt, 32'd0);

        // Single-cycle hit vectors; memory must stay untouched.
        rd_before = rd_cnt;
        for (int i = 0; i < 7; i++) begin
            read = vecs[i].rd; write = vecs[i].wr;
            address = vecs[i].addr; writedata = vecs[i].wd;
            @(negedge CLK);
            chk({vecs[i].name, "_busy"}, {31'b0, busywait}, {31'b0, vecs[i].exp_busy});
            chk({vecs[i].name, "_data"}, {24'b0, readdata}, {24'b0, vecs[i].exp_rd});
            chk({vecs[i].name, "_strobes"}, {30'b0, mem_read, mem_write}, 32'd0);
            @(posedge CLK); #1;
        end
        read = 1'b0; write = 1'b0;
        chk("hits_no_fetch", rd_cnt, rd_before);
        chk("hits_no_wb", wr_cnt, 32'd0);

        // Dirty conflict miss on 0x20: writeback of the modified block, then fetch of block 8.
        access(1'b1, 1'b0, 8'h20, 8'h00, stalls, rv, fb);
        chk("miss20_first_busy", {31'b0, fb}, 32'd1);
        chk("miss20_stalls", stalls, 32'd10);
        chk("miss20_wr_cnt", wr_cnt, 32'd1);
        chk("miss20_wb_addr", {26'b0, last_wr_addr}, 32'h00);
        chk("miss20_wb_data", last_wr_data, 32'h4433AB11);
        chk("miss20_rd_addr", {26'b0, last_rd_addr}, 32'h08);
        chk("miss20_readdata", {24'b0, rv}, 32'h55);

        // Reset during FETCH: read 0x00 misses on the clean line, then reset mid-transfer.
        rd_before = rd_cnt;
        wr_before = wr_cnt;
        read = 1'b1; address = 8'h00;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge CLK);
                seen = mem_read;
            end
            chk("abort_fetch_started", {31'b0, seen}, 32'd1);
        end
        RESET = 1'b0; read = 1'b0;
        @(negedge CLK);
        chk("abort_mem_read", {31'b0, mem_read}, 32'd0);
        chk("abort_mem_write", {31'b0, mem_write}, 32'd0);
        chk("abort_busywait", {31'b0, busywait}, 32'd0);
        chk("abort_readdata", {24'b0, readdata}, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        chk("abort_no_fetch", rd_cnt, rd_before);
        chk("abort_no_wb", wr_cnt, wr_before);

        // Line 0 was invalidated, so 0x20 misses again (clean: no writeback).
        access(1'b1, 1'b0, 8'h20, 8'h00, stalls, rv, fb);
        chk("remiss20_first_busy", {31'b0, fb}, 32'd1);
        chk("remiss20_stalls", stalls, 32'd6);
        chk("remiss20_readdata", {24'b0, rv}, 32'h55);
        chk("remiss20_rd_cnt", rd_cnt, rd_before + 1);
        chk("remiss20_wr_cnt", wr_cnt, wr_before);

        // read+write together at 0x05 behaves as a write-allocate store.
        access(1'b1, 1'b1, 8'h05, 8'h5A, stalls, rv, fb);
        chk("rw05_first_busy", {31'b0, fb}, 32'd1);
        chk("rw05_stalls", stalls, 32'd6);
        chk("rw05_rd_addr", {26'b0, last_rd_addr}, 32'h01);
        rd_before = rd_cnt;
        access(1'b1, 1'b0, 8'h05, 8'h00, stalls, rv, fb);
        chk("rd05_stalls", stalls, 32'd0);
        chk("rd05_readdata", {24'b0, rv}, 32'h5A);
        access(1'b1, 1'b0, 8'h06, 8'h00, stalls, rv, fb);
        chk("rd06_readdata", {24'b0, rv}, 32'hCC);
        chk("rd05_no_fetch", rd_cnt, rd_before);

        // Evicting line 1 must write back the stored byte, proving dirty was set.
        wr_before = wr_cnt;
        access(1'b1, 1'b0, 8'h24, 8'h00, stalls, rv, fb);
        chk("miss24_stalls", stalls, 32'd10);
        chk("miss24_wr_cnt", wr_cnt, wr_before + 1);
        chk("miss24_wb_addr", {26'b0, last_wr_addr}, 32'h01);
        chk("miss24_wb_data", last_wr_data, 32'hDDCC5AAA);
        chk("miss24_readdata", {24'b0, rv}, 32'h78);

        chk("strobe_overlap", overlap, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 Parameters: none; geometry SHALL be fixed at 8 blocks x 4 bytes, direct-mapped, write-back, write-allocate.
REQ-002 CLK  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 RESET  input  1  synchronous, active-low reset: sampled on the rising edge of CLK, asserted when 0.
REQ-004 read  input  1  CPU load request, held until busywait low.
REQ-005 write  input  1  CPU store request, held until busywait low.
REQ-006 address  input  8  CPU byte address: tag[7:5], index[4:2], offset[1:0].
REQ-007 writedata  input  8  CPU store byte.
REQ-008 readdata  output  8  CPU load byte.
REQ-009 busywait  output  1  stall to CPU.
REQ-010 mem_read  output  1  block fetch strobe to data memory.
REQ-011 mem_write  output  1  block writeback strobe to data memory.
REQ-012 mem_address  output  6  block address {tag,index}.
REQ-013 mem_writedata  output  32  victim block.
REQ-014 mem_readdata  input  32  fetched block; byte k at bits [8k+7:8k].
REQ-015 mem_busywait  input  1  memory busy; transfer complete on the first rising edge where it is 0 while a strobe is high.

Function
REQ-016 Storage SHALL be per-line data[31:0], tag[2:0], valid, dirty; offset k selects bits [8k+7:8k].
REQ-017 States SHALL be IDLE, WRITEBACK, FETCH, FILL.
REQ-018 hit SHALL be valid[index] && tag[index]==address[7:5], evaluated combinationally.
REQ-019 In IDLE with read or write asserted: busywait SHALL equal !hit in the same cycle; with neither asserted, busywait=0.
REQ-020 Read hit: readdata SHALL show the selected byte combinationally; zero-cycle added latency.
REQ-021 Write hit: on the next rising edge, the selected byte SHALL be written and dirty[index] set; memory is not touched.
REQ-022 Miss in IDLE: next state SHALL be WRITEBACK if valid&&dirty, else FETCH.
REQ-023 WRITEBACK: mem_write=1, mem_address={tag[index],index}, mem_writedata=data[index]; on completion go to FETCH.
REQ-024 FETCH: mem_read=1, mem_address={address[7:5],index}; on completion go to FILL.
REQ-025 FILL (one cycle): data<=mem_readdata, tag<=address[7:5], valid<=1, dirty<=0; go to IDLE, where the retried access hits.
REQ-026 busywait SHALL be 1 in WRITEBACK, FETCH and FILL; mem_read and mem_write SHALL never both be 1.
REQ-027 mem_read and mem_write SHALL be 0 in IDLE and FILL; mem_address and mem_writedata are don't-care when both strobes are low.
REQ-028 read and write both asserted SHALL be treated as write.
REQ-029 Requests SHALL be sampled only in IDLE; changing address while busywait=1 is illegal, and the block behaves per latched state.
REQ-030 Miss penalty SHALL be (WB cycles if dirty) + fetch cycles + 1 FILL cycle + final hit cycle.

Reset
REQ-031 RESET=0 at a rising edge SHALL clear all valid and dirty bits and force the state to IDLE.
REQ-032 During and after reset: mem_read=0, mem_write=0, busywait=0 (no request), readdata=0 when no request.
REQ-033 Reset asserted mid-WRITEBACK or mid-FETCH SHALL abort the transfer, drop the strobes on that edge, and leave the line unmodified apart from the cleared valid and dirty bits; data and tag contents need not be cleared.

Verification
REQ-034 Reset, then read 0x00 with memory block 0 = 0x44332211 and a 3-cycle mem_busywait -> busywait=1; one mem_read with mem_address=0; then a FILL cycle; then readdata=0x11 and busywait=0.
REQ-035 Follow-up read 0x03 -> hit: busywait=0 in the same cycle, readdata=0x44, no mem strobe.
REQ-036 Write 0xAB to 0x01 (hit) -> byte updated and dirty set with no memory traffic; read 0x01 -> 0xAB.
REQ-037 Read 0x20 (same index 0, tag 1) with line 0 dirty -> mem_write with mem_address=0x00 and mem_writedata=0x4433AB11, then mem_read with mem_address=0x08, then hit.
REQ-038 Pull RESET low during FETCH -> strobes low on the next edge; a subsequent read 0x20 misses again.
REQ-039 Assert read and write together at 0x05 -> treated as a write: byte 1 of line 1 written after the fill.
